// File: rtl/multicycle_control_pkg.sv
// Purpose : shared encodings for the multi-cycle RV64 control sequencer.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BEQ
    } mc_state_t;

    // Supported major opcodes (instr[6:0])
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // alu_op requests from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU B mux
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Purpose : control bundle between the sequencer and the datapath / IR.
// Latency : n/a (wiring only).
// Backpr. : none; the sequencer never stalls.
// master = control sequencer (consumes instruction fields and zero, drives
// selects/enables); slave = datapath side.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7b5, zero,
        output pc_write, adr_src, ir_write, mem_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, illegal
    );

    modport slave (
        output opcode, funct3, funct7b5, zero,
        input  pc_write, adr_src, ir_write, mem_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, illegal
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Purpose : maps alu_op + funct3/funct7b5 to the 3-bit ALU control word.
// Latency : purely combinational.
// Backpr. : none.
// Ports: alu_op (00 add, 01 sub, 10 funct), funct3, funct7b5, is_rtype in;
//        alu_control, illegal out.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_control,
    output logic       illegal
);
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        unique case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct3)
                    // funct7b5 selects SUB only for register-register ops;
                    // for addi it is just an immediate bit.
                    3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    default: illegal     = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Purpose : FSM sequencing the multi-cycle RV64 datapath (ld/sd/R/I/beq).
// Latency : ld 5, sd/R/I 4, beq 3, illegal opcode 2, illegal funct3 3 cycles.
// Backpr. : none; one state per clock, outputs forced to 0 while in reset.
// Ports: clk, rst_n (async active-low); ctl (master modport) carries the
// instruction fields and zero in, and all datapath selects/enables out.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master ctl
);
    mc_state_t  state, state_nxt;
    logic [1:0] alu_op;
    logic [2:0] dec_alu_control;
    logic       dec_illegal;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (ctl.funct3),
        .funct7b5    (ctl.funct7b5),
        .is_rtype    (state == S_EXEC_R),
        .alu_control (dec_alu_control),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        alu_op          = ALUOP_ADD;
        ctl.pc_write    = 1'b0;
        ctl.adr_src     = 1'b0;
        ctl.ir_write    = 1'b0;
        ctl.mem_write   = 1'b0;
        ctl.reg_write   = 1'b0;
        ctl.result_src  = RES_ALUOUT;
        ctl.alu_src_a   = SRCA_PC;
        ctl.alu_src_b   = SRCB_RS2;
        ctl.illegal     = 1'b0;

        unique case (state)
            S_FETCH: begin
                ctl.ir_write   = 1'b1;
                ctl.pc_write   = 1'b1;
                ctl.alu_src_b  = SRCB_FOUR;
                ctl.result_src = RES_ALURESULT;
                state_nxt      = S_DECODE;
            end
            S_DECODE: begin
                // Branch target (old PC + imm) lands in the ALU-out register.
                ctl.alu_src_a = SRCA_OLDPC;
                ctl.alu_src_b = SRCB_IMM;
                unique case (ctl.opcode)
                    OP_LD, OP_SD: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC_R;
                    OP_ITYPE:     state_nxt = S_EXEC_I;
                    OP_BEQ:       state_nxt = S_BEQ;
                    default: begin
                        ctl.illegal = 1'b1;
                        state_nxt   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
                state_nxt     = (ctl.opcode == OP_LD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctl.adr_src = 1'b1;
                state_nxt   = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.result_src = RES_MEMDATA;
                ctl.reg_write  = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_MEMWRITE: begin
                ctl.adr_src   = 1'b1;
                ctl.mem_write = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_op        = ALUOP_FUNCT;
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = (state == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                ctl.illegal   = dec_illegal;
                // An unsupported funct3 skips writeback entirely.
                state_nxt     = dec_illegal ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ctl.reg_write = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_BEQ: begin
                alu_op        = ALUOP_SUB;
                ctl.alu_src_a = SRCA_RS1;
                ctl.pc_write  = ctl.zero;
                state_nxt     = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        ctl.alu_control = dec_alu_control;

        // Reset must not leak a write enable or pulse onto the datapath.
        if (!rst_n) begin
            ctl.pc_write    = 1'b0;
            ctl.adr_src     = 1'b0;
            ctl.ir_write    = 1'b0;
            ctl.mem_write   = 1'b0;
            ctl.reg_write   = 1'b0;
            ctl.result_src  = 2'b00;
            ctl.alu_src_a   = 2'b00;
            ctl.alu_src_b   = 2'b00;
            ctl.alu_control = 3'b000;
            ctl.illegal     = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] SD  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [14:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_control_if mc();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (mc)
    );

    // {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
    //  alu_src_a, alu_src_b, alu_control, illegal}
    wire [14:0] obs = {mc.pc_write, mc.adr_src, mc.ir_write, mc.mem_write,
                       mc.reg_write, mc.result_src, mc.alu_src_a,
                       mc.alu_src_b, mc.alu_control, mc.illegal};

    function automatic logic [14:0] mk(logic pcw, logic adr, logic irw,
                                       logic memw, logic regw, logic [1:0] res,
                                       logic [1:0] a, logic [1:0] b,
                                       logic [2:0] alu, logic ill);
        return {pcw, adr, irw, memw, regw, res, a, b, alu, ill};
    endfunction

    function automatic bit supported(logic [6:0] op);
        return op == LD || op == SD || op == RT || op == IT || op == BQ;
    endfunction

    // Reference: per-instruction list of control words, one per cycle.
    function automatic void build(logic [6:0] op, logic [2:0] f3, logic f7, logic z);
        logic [2:0] aluc;
        logic       ill;
        exp_q.delete();
        exp_q.push_back(mk(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'd0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0, !supported(op)));
        if (op == LD || op == SD) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, 0));
            if (op == LD) begin
                exp_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'd0, 0));
            end else begin
                exp_q.push_back(mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'd0, 0));
            end
        end else if (op == RT || op == IT) begin
            ill  = 0;
            case (f3)
                3'b000:  aluc = (op == RT && f7) ? 3'd1 : 3'd0;
                3'b111:  aluc = 3'd2;
                3'b110:  aluc = 3'd3;
                default: begin aluc = 3'd0; ill = 1; end
            endcase
            exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10,
                               (op == IT) ? 2'b01 : 2'b00, aluc, ill));
            if (!ill)
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 0));
        end else if (op == BQ) begin
            exp_q.push_back(mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'd1, 0));
        end
    endfunction

    task automatic chk(string tag, logic [14:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Runs one instruction from FETCH; entered and left at a falling edge.
    // abort_at >= 0 pulls reset in that cycle and abandons the instruction.
    task automatic run(string tag, logic [6:0] op, logic [2:0] f3,
                       logic f7, logic z, int abort_at);
        build(op, f3, f7, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            mc.opcode   = op;
            mc.funct3   = f3;
            mc.funct7b5 = f7;
            mc.zero     = z;
            #1;
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk($sformatf("%s_rst_c%0d", tag, i + 1), 15'd0);
                @(posedge clk);
                @(negedge clk);
                chk($sformatf("%s_rst_hold", tag), 15'd0);
                rst_n = 1'b1;
                #1;
                return;
            end
            chk($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
            if (op == BQ && i == 2) begin
                // pc_write must follow zero within the cycle.
                mc.zero = ~z;
                #1;
                chk($sformatf("%s_zflip", tag), exp_q[i] ^ 15'h4000);
                mc.zero = z;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [6:0] op;
        logic [6:0] ops[5];
        ops[0] = LD; ops[1] = SD; ops[2] = RT; ops[3] = IT; ops[4] = BQ;
        rst_n       = 1'b0;
        mc.opcode   = RT;
        mc.funct3   = 3'b000;
        mc.funct7b5 = 1'b0;
        mc.zero     = 1'b0;

        // Reset held for 3 cycles: everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset_c%0d", i), 15'd0);
        end
        rst_n = 1'b1;

        // Directed steps
        run("add",  RT, 3'b000, 1'b0, 1'b0, -1);
        run("sub",  RT, 3'b000, 1'b1, 1'b0, -1);
        run("and",  RT, 3'b111, 1'b0, 1'b0, -1);
        run("or",   RT, 3'b110, 1'b0, 1'b0, -1);
        run("addi", IT, 3'b000, 1'b1, 1'b0, -1);
        run("ori",  IT, 3'b110, 1'b1, 1'b1, -1);
        run("ld",   LD, 3'b011, 1'b0, 1'b1, -1);
        run("sd",   SD, 3'b011, 1'b0, 1'b1, -1);
        run("beq1", BQ, 3'b000, 1'b0, 1'b1, -1);
        run("beq0", BQ, 3'b000, 1'b0, 1'b0, -1);
        run("badop", 7'b1111111, 3'b000, 1'b0, 1'b0, -1);
        run("badf3", RT, 3'b001, 1'b0, 1'b0, -1);
        run("ld_rst", LD, 3'b011, 1'b0, 1'b0, 3);
        run("after_rst", RT, 3'b111, 1'b0, 1'b0, -1);

        // Randomized instruction mix
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do op = 7'($urandom); while (supported(op));
            end else begin
                op = ops[$urandom_range(0, 4)];
            end
            run($sformatf("rnd%0d_op%b", n, op), op, 3'($urandom),
                1'($urandom), 1'($urandom),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
